// File: rtl/load_store_unit.sv
// Load/store unit: one CPU load/store at a time against a word-wide data memory, with byte/halfword
// extraction on loads and read-modify-write on sub-word stores. Optional feature macro: MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data
);

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Pull the addressed lane down to bit 0 and extend it to a full word.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] off);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_BYTE: r[{off, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (off[1]) begin
          r[31:16] = wdata[15:0];
        end else begin
          r[15:0] = wdata[15:0];
        end
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  state_t              state_r;
  state_t              state_next;
  logic                accept_s;
  logic                write_r;
  logic [1:0]          size_r;
  logic                signed_r;
  logic [1:0]          off_r;
  logic [31:0]         wdata_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [ADDR_W-1:0]   addr_next;
  logic [31:0]         mem_wdata_r;
  logic [31:0]         mem_wdata_next;
  logic [31:0]         rdata_r;
  logic [31:0]         rdata_next;
  logic                mem_read_r;
  logic                mem_write_r;
  logic                resp_valid_r;
  logic [1:0]          size_norm_s;
  logic [1:0]          off_norm_s;

  assign req_ready      = rst_n & (state_r == IDLE);
  assign accept_s       = req_valid & req_ready;
  assign resp_valid     = resp_valid_r;
  assign resp_rdata     = rdata_r;
  assign mem_read       = mem_read_r;
  assign mem_write      = mem_write_r;
  assign mem_write_data = mem_wdata_r;
  assign mem_address    = {{(32 - ADDR_W){1'b0}}, addr_r};

  // Size 3 behaves as word; misaligned low address bits are dropped for the lane select.
  always_comb begin
    size_norm_s = req_size[1] ? SZ_WORD : req_size;
    case (size_norm_s)
      SZ_BYTE: off_norm_s = req_addr[1:0];
      SZ_HALF: off_norm_s = {req_addr[1], 1'b0};
      default: off_norm_s = 2'b00;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_s;
  logic err_r;
  logic err_next;
  assign misalign_s = (req_size[1] && (req_addr[1:0] != 2'b00)) ||
                      ((req_size == SZ_HALF) && req_addr[0]);
  assign resp_err   = err_r;
`else
  assign resp_err   = 1'b0;
`endif

  // Next-state and datapath-next logic of the access sequencer.
  always_comb begin
    state_next     = state_r;
    addr_next      = addr_r;
    mem_wdata_next = mem_wdata_r;
    rdata_next     = 32'h0000_0000;
`ifdef MISALIGN_TRAP_EN
    err_next       = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          addr_next = req_addr[ADDR_W+1:2];
`ifdef MISALIGN_TRAP_EN
          if (misalign_s) begin
            state_next = RESP;
            err_next   = 1'b1;
          end else
`endif
          if (!req_write) begin
            state_next = READ;
          end else if (req_size[1]) begin
            state_next     = WRITE;
            mem_wdata_next = req_wdata;
          end else begin
            state_next = READ;
          end
        end else begin
          state_next = IDLE;
        end
      end
      READ: begin
        if (write_r) begin
          state_next     = WRITE;
          mem_wdata_next = store_merge(mem_read_data, wdata_r, size_r, off_r);
        end else begin
          state_next = RESP;
          rdata_next = load_extract(mem_read_data, size_r, off_r, signed_r);
        end
      end
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and output registers; strobes are registered copies of the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      addr_r       <= '0;
      mem_wdata_r  <= 32'h0000_0000;
      rdata_r      <= 32'h0000_0000;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      resp_valid_r <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      err_r        <= 1'b0;
`endif
    end else begin
      state_r      <= state_next;
      addr_r       <= addr_next;
      mem_wdata_r  <= mem_wdata_next;
      rdata_r      <= rdata_next;
      mem_read_r   <= (state_next == READ);
      mem_write_r  <= (state_next == WRITE);
      resp_valid_r <= (state_next == RESP);
`ifdef MISALIGN_TRAP_EN
      err_r        <= err_next;
`endif
    end
  end

  // Request fields captured at acceptance and held for the whole access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_r  <= 1'b0;
      size_r   <= SZ_BYTE;
      signed_r <= 1'b0;
      off_r    <= 2'b00;
      wdata_r  <= 32'h0000_0000;
    end else if (accept_s) begin
      write_r  <= req_write;
      size_r   <= size_norm_s;
      signed_r <= req_signed;
      off_r    <= off_norm_s;
      wdata_r  <= req_wdata;
    end else begin
      write_r  <= write_r;
      size_r   <= size_r;
      signed_r <= signed_r;
      off_r    <= off_r;
      wdata_r  <= wdata_r;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: word-indexed memory model, hand-computed expected results.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:255];
  int checks;
  int failures;

  load_store_unit #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read(mem_read), .mem_write(mem_write),
    .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address[7:0]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_address[7:0]] <= mem_write_data;
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  int          lat;
  int          nrd;
  int          nwr;
  int          npulse;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] seen_addr;

  // Issue one request and watch 8 cycles after acceptance.
  task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_write = wr; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = ~wr; req_size = 2'd0; req_signed = ~sg; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
    lat = 0; nrd = 0; nwr = 0; npulse = 0; rdata = 32'h0; err = 1'b0; seen_addr = 32'hFFFF_FFFF;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (mem_read)  begin nrd++; seen_addr = mem_address; end
      if (mem_write) begin nwr++; seen_addr = mem_address; end
      if (resp_valid) begin
        npulse++;
        if (lat == 0) begin
          lat = cyc; rdata = resp_rdata; err = resp_err;
        end
      end
    end
  endtask

  task automatic expect_resp(input string tag, input int e_lat, input logic [31:0] e_rdata,
                             input int e_rd, input int e_wr);
    check({tag, "_lat"}, lat, e_lat);
    check({tag, "_rdata"}, rdata, e_rdata);
    check({tag, "_nrd"}, nrd, e_rd);
    check({tag, "_nwr"}, nwr, e_wr);
    check({tag, "_pulse"}, npulse, 32'd1);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[3] = 32'h8899_AABB;
    mem[5] = 32'h1122_3344;

    #3;
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", {31'd0, resp_err}, 32'd0);
    check("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_addr", mem_address, 32'h0);
    check("rst_wdata", mem_write_data, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", {31'd0, req_ready}, 32'd1);

    run_req(1'b0, 2'd0, 1'b1, 32'h0000_000D, 32'h0);
    expect_resp("ld_b_s_0d", 2, 32'hFFFF_FFAA, 1, 0);
    run_req(1'b0, 2'd1, 1'b0, 32'h0000_000E, 32'h0);
    expect_resp("ld_h_u_0e", 2, 32'h0000_8899, 1, 0);
    run_req(1'b0, 2'd0, 1'b0, 32'h0000_000F, 32'h0);
    expect_resp("ld_b_u_0f", 2, 32'h0000_0088, 1, 0);
    run_req(1'b0, 2'd1, 1'b1, 32'h0000_000C, 32'h0);
    expect_resp("ld_h_s_0c", 2, 32'hFFFF_AABB, 1, 0);
    run_req(1'b0, 2'd3, 1'b1, 32'h0000_000C, 32'h0);
    expect_resp("ld_w3_0c", 2, 32'h8899_AABB, 1, 0);

    run_req(1'b1, 2'd0, 1'b0, 32'h0000_000C, 32'hFFFF_FF5C);
    expect_resp("st_b_0c", 3, 32'h0, 1, 1);
    check("st_b_0c_mem", mem[3], 32'h8899_AA5C);
    run_req(1'b1, 2'd1, 1'b0, 32'h0000_000E, 32'hABCD_1234);
    expect_resp("st_h_0e", 3, 32'h0, 1, 1);
    check("st_h_0e_mem", mem[3], 32'h1234_AA5C);

    run_req(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
    expect_resp("st_w_10", 2, 32'h0, 0, 1);
    check("st_w_10_mem", mem[4], 32'hDEAD_BEEF);

    run_req(1'b0, 2'd2, 1'b0, 32'h0000_0410, 32'h0);
    expect_resp("ld_w_wrap", 2, 32'hDEAD_BEEF, 1, 0);
    check("ld_w_wrap_addr", seen_addr, 32'h0000_0004);
    run_req(1'b1, 2'd0, 1'b0, 32'h0000_0413, 32'h0000_0077);
    expect_resp("st_b_wrap", 3, 32'h0, 1, 1);
    check("st_b_wrap_mem", mem[4], 32'h77AD_BEEF);

`ifdef MISALIGN_TRAP_EN
    run_req(1'b0, 2'd2, 1'b0, 32'h0000_000E, 32'h0);
    check("mis_w_lat", lat, 32'd1);
    check("mis_w_err", {31'd0, err}, 32'd1);
    check("mis_w_rdata", rdata, 32'h0);
    check("mis_w_strobes", nrd + nwr, 32'd0);
    run_req(1'b1, 2'd1, 1'b0, 32'h0000_0011, 32'h0000_5555);
    check("mis_h_st_err", {31'd0, err}, 32'd1);
    check("mis_h_st_strobes", nrd + nwr, 32'd0);
    check("mis_h_st_mem", mem[4], 32'h77AD_BEEF);
`else
    run_req(1'b0, 2'd2, 1'b0, 32'h0000_000E, 32'h0);
    expect_resp("mis_w_ld", 2, 32'h1234_AA5C, 1, 0);
    run_req(1'b0, 2'd1, 1'b0, 32'h0000_000F, 32'h0);
    expect_resp("mis_h_ld", 2, 32'h0000_1234, 1, 0);
`endif

    // Reset while the read half of a byte store is in flight.
    @(negedge clk);
    req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h0000_0014;
    req_wdata = 32'h0000_00EE; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_in_read", {31'd0, mem_read}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_rst_ready", {31'd0, req_ready}, 32'd0);
    check("abort_rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    nwr = 0;
    repeat (2) begin
      @(negedge clk);
      if (mem_write) nwr++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (mem_write || resp_valid) nwr++;
    end
    check("abort_no_write", nwr, 32'd0);
    check("abort_mem", mem[5], 32'h1122_3344);
    check("abort_idle_ready", {31'd0, req_ready}, 32'd1);

    run_req(1'b0, 2'd0, 1'b1, 32'h0000_0017, 32'h0);
    expect_resp("after_abort_ld", 2, 32'h0000_0011, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
